anton_neopixel_pixel_loader: RTL and testbench

//  Upstream feeder for the neopixel module's byte bus. Accepts whole pixels on a

---
 rtl/anton_neopixel_pixel_loader.sv | 112 +++++++++++
 tb/tb_anton_neopixel_pixel_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_pixel_loader.sv
// anton_neopixel_pixel_loader: serialises GRB(W) pixels into byte-bus writes for the
// neopixel pixel buffer and launches the frame via regMax/control writes on the last pixel.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 14'h3EFF
`endif

module anton_neopixel_pixel_loader #(
   parameter logic [13:0] BUFFER_END = `BUFFER_END_DEFAULT,
   parameter logic [13:0] REG_MAX_LO = 14'h3F00,
   parameter logic [13:0] REG_MAX_HI = 14'h3F01,
   parameter logic [13:0] REG_CTRL   = 14'h3F02,
   parameter logic [7:0]  CTRL_VALUE = 8'h04,
   parameter bit          SAFE_WRITE = 1'b1
) (
   input  logic        busClk,
   input  logic        busResetN,
   input  logic        pixelValid,
   output logic        pixelReady,
   input  logic [31:0] pixelData,
   input  logic        pixelLast,
   input  logic        mode32,
   input  logic        neoState,
   output logic [13:0] busAddr,
   output logic [7:0]  busDataIn,
   output logic        busWrite,
   output logic        busy,
   output logic        overflow
);
   typedef enum logic [2:0] {IDLE, HOLD, ACCEPT, EMIT, MAXLO, MAXHI, CTRL} state_t;
   state_t      state_q;
   logic [31:0] pix_q;
   logic        last_q, m32_q;
   logic [1:0]  idx_q;
   logic [13:0] ptr_q;
   logic [7:0]  byte_d;
   logic [12:0] reg_max_d;
   logic        final_byte, hold_req;

   always_comb begin
      byte_d = idx_q == 2'd0 ? pix_q[15:8] :
               idx_q == 2'd1 ? pix_q[23:16] :
               idx_q == 2'd2 ? pix_q[7:0] : pix_q[31:24];
   end

   // The pointer only advances on real writes, so it is one past the last written byte.
   assign reg_max_d  = ptr_q == '0 ? '0 : ptr_q[12:0] - 13'd1;
   assign final_byte = idx_q == (m32_q ? 2'd3 : 2'd2);
   assign hold_req   = SAFE_WRITE && neoState;
   assign pixelReady = state_q == ACCEPT;

   always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
         state_q   <= IDLE;
         pix_q     <= '0;
         last_q    <= 1'b0;
         m32_q     <= 1'b0;
         idx_q     <= '0;
         ptr_q     <= '0;
         busAddr   <= '0;
         busDataIn <= '0;
         busWrite  <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         busWrite <= 1'b0;
         case (state_q)
            IDLE: state_q <= hold_req ? HOLD : ACCEPT;
            HOLD: if (!neoState) state_q <= ACCEPT;
            ACCEPT: if (pixelValid) begin
               pix_q   <= pixelData;
               last_q  <= pixelLast;
               m32_q   <= mode32;
               idx_q   <= '0;
               busy    <= 1'b1;
               if (!busy) overflow <= 1'b0;
               state_q <= EMIT;
            end
            EMIT: begin
               if (ptr_q <= BUFFER_END) begin
                  busWrite  <= 1'b1;
                  busAddr   <= ptr_q;
                  busDataIn <= byte_d;
                  ptr_q     <= ptr_q + 14'd1;
               end else overflow <= 1'b1;
               idx_q <= idx_q + 2'd1;
               if (final_byte) state_q <= last_q ? MAXLO : (hold_req ? HOLD : ACCEPT);
            end
            MAXLO: begin
               busWrite  <= 1'b1;
               busAddr   <= REG_MAX_LO;
               busDataIn <= reg_max_d[7:0];
               state_q   <= MAXHI;
            end
            MAXHI: begin
               busWrite  <= 1'b1;
               busAddr   <= REG_MAX_HI;
               busDataIn <= {3'b000, reg_max_d[12:8]};
               state_q   <= CTRL;
            end
            CTRL: begin
               busWrite  <= 1'b1;
               busAddr   <= REG_CTRL;
               busDataIn <= CTRL_VALUE;
               ptr_q     <= '0;
               busy      <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_anton_neopixel_pixel_loader.sv
// tb_anton_neopixel_pixel_loader: two loaders (roomy and 6-byte buffer) driven in lockstep,
// write streams compared against a byte-list model of the frame.
module tb_anton_neopixel_pixel_loader;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        pixelValid = 1'b0, pixelLast = 1'b0, mode32 = 1'b0, neoState = 1'b0;
   logic [31:0] pixelData = '0;
   logic        rdy40, bw40, busy40, ovf40, rdy5, bw5, busy5, ovf5;
   logic [13:0] a40, a5;
   logic [7:0]  d40, d5;
   int          errors = 0, checks = 0, cyc = 0;
   logic [21:0] obs40[$], obs5[$];
   logic [31:0] px_q[$];
   logic        md_q[$];
   logic [7:0]  bq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bw40) obs40.push_back({a40, d40});
      if (bw5) obs5.push_back({a5, d5});
   end

   anton_neopixel_pixel_loader #(.BUFFER_END(14'd40)) dut40 (
      .busClk(clk), .busResetN(rst_n), .pixelValid(pixelValid), .pixelReady(rdy40),
      .pixelData(pixelData), .pixelLast(pixelLast), .mode32(mode32), .neoState(neoState),
      .busAddr(a40), .busDataIn(d40), .busWrite(bw40), .busy(busy40), .overflow(ovf40));

   anton_neopixel_pixel_loader #(.BUFFER_END(14'd5)) dut5 (
      .busClk(clk), .busResetN(rst_n), .pixelValid(pixelValid), .pixelReady(rdy5),
      .pixelData(pixelData), .pixelLast(pixelLast), .mode32(mode32), .neoState(neoState),
      .busAddr(a5), .busDataIn(d5), .busWrite(bw5), .busy(busy5), .overflow(ovf5));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int written(input int be);
      return bq.size() < be + 1 ? bq.size() : be + 1;
   endfunction

   function automatic logic [21:0] exp_entry(input int be, input int j);
      int w = written(be);
      logic [12:0] rm = w > 0 ? 13'(w - 1) : 13'd0;
      if (j < w) return {14'(j), bq[j]};
      if (j == w) return {14'h3F00, rm[7:0]};
      if (j == w + 1) return {14'h3F01, 3'b000, rm[12:8]};
      return {14'h3F02, 8'h04};
   endfunction

   task automatic compare_frame(input string tag);
      int t = 0;
      while (obs40.size() < written(40) + 3 && t < 200) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      check({tag, "_cnt40"}, obs40.size(), written(40) + 3);
      check({tag, "_cnt5"}, obs5.size(), written(5) + 3);
      for (int j = 0; j < obs40.size() && j < written(40) + 3; j++)
         check($sformatf("%s_w40_%0d", tag, j), obs40[j], exp_entry(40, j));
      for (int j = 0; j < obs5.size() && j < written(5) + 3; j++)
         check($sformatf("%s_w5_%0d", tag, j), obs5[j], exp_entry(5, j));
      check({tag, "_busy"}, {busy40, busy5}, 2'b00);
      check({tag, "_ovf40"}, ovf40, bq.size() > 41);
      check({tag, "_ovf5"}, ovf5, bq.size() > 6);
   endtask

   task automatic send_frame(input string tag, input int hold);
      int t, prev;
      bq.delete();
      for (int i = 0; i < px_q.size(); i++) begin
         bq.push_back(px_q[i][15:8]);
         bq.push_back(px_q[i][23:16]);
         bq.push_back(px_q[i][7:0]);
         if (md_q[i]) bq.push_back(px_q[i][31:24]);
      end
      obs40.delete();
      obs5.delete();
      if (hold > 0) begin
         pixelValid = 1'b1;
         pixelData  = px_q[0];
         repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_rdy"}, {rdy40, rdy5}, 2'b00);
            check({tag, "_hold_wr"}, obs40.size() + obs5.size(), 0);
         end
         neoState = 1'b0;
      end
      prev = 0;
      for (int i = 0; i < px_q.size(); i++) begin
         pixelValid = 1'b1;
         pixelData  = px_q[i];
         pixelLast  = i == px_q.size() - 1;
         mode32     = md_q[i];
         t = 0;
         while (!rdy40 && t < 50) begin @(negedge clk); t++; end
         check({tag, "_rdy_wait"}, t < 50, 1'b1);
         @(negedge clk);
         mode32 = ~mode32;
         if (i == 0) begin
            check({tag, "_busy_rise"}, {busy40, busy5}, 2'b11);
            check({tag, "_ovf_clr"}, {ovf40, ovf5}, 2'b00);
         end else check($sformatf("%s_spacing_%0d", tag, i), cyc - prev, md_q[i-1] ? 5 : 4);
         prev = cyc;
      end
      pixelValid = 1'b0;
      pixelLast  = 1'b0;
      compare_frame(tag);
   endtask

   task automatic set_random(input int n, input int mode);
      px_q.delete();
      md_q.delete();
      for (int i = 0; i < n; i++) begin
         px_q.push_back($urandom);
         md_q.push_back(mode == 2 ? 1'($urandom_range(0, 1)) : 1'(mode));
      end
   endtask

   initial begin
      #12;
      check("reset_outs", {rdy40, bw40, busy40, ovf40, a40, d40, rdy5, bw5, busy5, ovf5, a5, d5}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      px_q = '{32'h00112233, 32'h00445566};
      md_q = '{1'b0, 1'b0};
      send_frame("grb2", 0);
      px_q = '{32'hAA112233};
      md_q = '{1'b1};
      send_frame("grbw1", 0);
      px_q = '{32'h00010203, 32'h00040506, 32'h00070809};
      md_q = '{1'b0, 1'b0, 1'b0};
      send_frame("ovf3", 0);
      set_random(4, 0);
      send_frame("stream4", 0);
      for (int k = 0; k < 6; k++) begin
         set_random($urandom_range(1, 12), 2);
         send_frame($sformatf("rnd%0d", k), 0);
      end
      set_random(2, 0);
      pixelValid = 1'b1;
      pixelData  = px_q[0];
      while (!rdy40) @(negedge clk);
      @(negedge clk);
      pixelValid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_second_byte", {bw40, a40}, {1'b1, 14'd1});
      #2 rst_n = 1'b0;
      #1 check("async_reset", {rdy40, bw40, busy40, ovf40, a40, d40, rdy5, bw5, busy5, ovf5, a5, d5}, '0);
      neoState = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      set_random(3, 2);
      send_frame("hold_restart", 10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
